// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the sram_1rw1r_wmask memory model:
//   - sramState_e : power-on fill sequencer states (INIT, READY)
//   - ramDepth()  : array depth derived from the address width
//   - expandMask(): widens a per-lane write mask into a per-bit mask
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        INIT,
        READY
    } sramState_e;

    // Upper bounds for expandMask; the top module refuses larger parameters.
    localparam int MAX_DATA_WIDTH  = 1024;
    localparam int MAX_WMASK_WIDTH = 128;

    // Depth is always a power of two, so every address is in range.
    function automatic int ramDepth(input int addrWidth);
        return 1 << addrWidth;
    endfunction

    // Each set mask bit turns on laneWidth consecutive bits. The mask is
    // consumed one lane at a time by shifting rather than indexing.
    function automatic logic [MAX_DATA_WIDTH-1:0] expandMask(
        input logic [MAX_WMASK_WIDTH-1:0] mask,
        input int                         laneWidth
    );
        logic [MAX_DATA_WIDTH-1:0]  laneOnes;
        logic [MAX_DATA_WIDTH-1:0]  result;
        logic [MAX_WMASK_WIDTH-1:0] rest;
        laneOnes = (MAX_DATA_WIDTH'(1) << laneWidth) - MAX_DATA_WIDTH'(1);
        result   = '0;
        rest     = mask;
        for (int i = 0; i < MAX_WMASK_WIDTH; i++) begin
            if (rest[0]) begin
                result = result | (laneOnes << (i * laneWidth));
            end
            rest = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// -----------------------------------------------------------------------------
// sram_init_seq
// Power-on zero-fill sequencer. After reset release (when INIT_ZERO=1) it
// walks every address once and hands a write-override request to the array.
//   clk_i       : clock (shared with the array)
//   rst_ni      : asynchronous active-low reset
//   initDone_o  : high once the array accepts user accesses
//   fillWe_o    : fill write strobe, committed by the array at the negedge
//   fillAddr_o  : address being filled
//   fillData_o  : fill data (all zero)
//   fillMask_o  : fill bit mask (all ones)
// -----------------------------------------------------------------------------
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  initDone_o,
    output logic                  fillWe_o,
    output logic [ADDR_WIDTH-1:0] fillAddr_o,
    output logic [DATA_WIDTH-1:0] fillData_o,
    output logic [DATA_WIDTH-1:0] fillMask_o
);

    localparam sramState_e RESET_STATE = (INIT_ZERO != 0) ? INIT : READY;

    sramState_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] fillAddr_q;
    logic                  fillWe_q;
    logic                  initDone_q;

    // The fill FSM. Every posedge spent in INIT registers a fill request for
    // the current counter value, so the array commits it at the following
    // negedge just like a captured user write. The edge that requests the
    // last address also moves to READY and raises initDone, which makes
    // initDone rise on the RAM_DEPTH-th posedge after release. A reset in
    // the middle of the fill drops the pending strobe and restarts from 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            fillAddr_q <= '0;
            fillWe_q   <= 1'b0;
            initDone_q <= (INIT_ZERO == 0);
        end else begin
            case (state_q)
                INIT: begin
                    fillWe_q   <= 1'b1;
                    fillAddr_q <= cnt_q;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q    <= READY;
                        initDone_q <= 1'b1;
                    end
                end
                READY: begin
                    fillWe_q <= 1'b0;
                end
            endcase
        end
    end

    assign initDone_o = initDone_q;
    assign fillWe_o   = fillWe_q;
    assign fillAddr_o = fillAddr_q;
    assign fillData_o = '0;
    assign fillMask_o = '1;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// -----------------------------------------------------------------------------
// sram_1rw1r_wmask
// Behavioural two-port SRAM: port 0 read/write with per-lane write mask,
// port 1 read-only, single clock, optional power-on zero fill.
//   clk0      : clock for both ports
//   rstb      : asynchronous active-low reset
//   csb0/web0 : port 0 chip select / write enable (active low)
//   wmask0    : port 0 lane enables for writes
//   addr0     : port 0 address      din0 : port 0 write data
//   dout0     : port 0 read data (1-cycle latency, holds when idle)
//   csb1      : port 1 chip select (active low)
//   addr1     : port 1 address      dout1 : port 1 read data
//   init_done : high when the array accepts accesses
// Inputs are captured at posedge; writes and read outputs update at negedge.
// -----------------------------------------------------------------------------
module sram_1rw1r_wmask
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4,
    parameter int INIT_ZERO   = 1,
    parameter int DELAY       = 0
) (
    input  logic                   clk0,
    input  logic                   rstb,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   init_done
);

    localparam int RAM_DEPTH = ramDepth(ADDR_WIDTH);
    localparam int LW        = DATA_WIDTH / WMASK_WIDTH;

    // Refuse parameter sets the lane logic cannot represent.
    if ((DATA_WIDTH % WMASK_WIDTH) != 0 || WMASK_WIDTH > MAX_WMASK_WIDTH ||
        DATA_WIDTH > MAX_DATA_WIDTH || DELAY < 0) begin : gParamCheck
        $error("sram_1rw1r_wmask: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic                   csb0_q;
    logic                   web0_q;
    logic [WMASK_WIDTH-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0]  addr0_q;
    logic [DATA_WIDTH-1:0]  din0_q;
    logic                   csb1_q;
    logic [ADDR_WIDTH-1:0]  addr1_q;
    logic [DATA_WIDTH-1:0]  dout0_q;
    logic [DATA_WIDTH-1:0]  dout1_q;

    logic                   initDone;
    logic                   fillWe;
    logic [ADDR_WIDTH-1:0]  fillAddr;
    logic [DATA_WIDTH-1:0]  fillData;
    logic [DATA_WIDTH-1:0]  fillMask;

    logic [DATA_WIDTH-1:0]  bitMask;
    logic [DATA_WIDTH-1:0]  merged_d;
    logic                   p0Write;
    logic                   p0Read;
    logic                   p1Read;

    sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_ZERO  (INIT_ZERO)
    ) u_initSeq (
        .clk_i      (clk0),
        .rst_ni     (rstb),
        .initDone_o (initDone),
        .fillWe_o   (fillWe),
        .fillAddr_o (fillAddr),
        .fillData_o (fillData),
        .fillMask_o (fillMask)
    );

    // Capture both ports at posedge. Until the array is ready the chip
    // selects are forced high so nothing captured during the fill can
    // write or disturb the read outputs.
    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            csb0_q   <= initDone ? csb0 : 1'b1;
            csb1_q   <= initDone ? csb1 : 1'b1;
            web0_q   <= web0;
            wmask0_q <= wmask0;
            addr0_q  <= addr0;
            din0_q   <= din0;
            addr1_q  <= addr1;
        end
    end

    // Decode the captured controls. An unknown control bit makes the port
    // do nothing, leaving the array and its output untouched. merged_d is
    // the post-mask word at addr0, used both for the write and for the
    // port 1 write-first bypass.
    always_comb begin
        bitMask  = DATA_WIDTH'(expandMask(MAX_WMASK_WIDTH'(wmask0_q), LW));
        p0Write  = !$isunknown({csb0_q, web0_q, wmask0_q, addr0_q}) && !csb0_q && !web0_q;
        p0Read   = !$isunknown({csb0_q, web0_q, addr0_q}) && !csb0_q && web0_q;
        p1Read   = !$isunknown({csb1_q, addr1_q}) && !csb1_q;
        merged_d = (mem[addr0_q] & ~bitMask) | (din0_q & bitMask);
    end

    // Array commit at negedge. The fill request and a user write can never
    // coincide because user captures are blocked until the fill is done.
    always_ff @(negedge clk0) begin
        if (fillWe) begin
            mem[fillAddr] <= (mem[fillAddr] & ~fillMask) | (fillData & fillMask);
        end else if (p0Write) begin
            mem[addr0_q] <= merged_d;
        end
    end

    // Read outputs update at the same negedge as the write. A port 1 read of
    // the address port 0 is writing returns the merged word (write-first).
    // Idle ports and port 0 writes keep the previous output value.
    always_ff @(negedge clk0 or negedge rstb) begin
        if (!rstb) begin
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            if (p0Read) begin
                dout0_q <= mem[addr0_q];
            end
            if (p1Read) begin
                dout1_q <= (p0Write && (addr1_q == addr0_q)) ? merged_d : mem[addr1_q];
            end
        end
    end

    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign init_done = initDone;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw1r_wmask
// Self-checking bench for sram_1rw1r_wmask with default parameters. A word-
// level array model plus expected read outputs is advanced once per access.
// -----------------------------------------------------------------------------
module tb_sram_1rw1r_wmask;

    logic        clk0;
    logic        rstb;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic        init_done;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          edgeCnt;

    logic [31:0] refMem [256];
    logic [31:0] refDout0;
    logic [31:0] refDout1;

    sram_1rw1r_wmask #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (8),
        .WMASK_WIDTH (4),
        .INIT_ZERO   (1),
        .DELAY       (0)
    ) dut (
        .clk0      (clk0),
        .rstb      (rstb),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1),
        .init_done (init_done)
    );

    // 10 time-unit clock.
    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Posedges since the last reset release; the array is usable for an
    // access whose capture edge comes after 256 such edges.
    always @(posedge clk0 or negedge rstb) begin
        if (!rstb) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    task automatic idleInputs();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'h0;
        addr0  = 8'h00;
        din0   = 32'h0;
        csb1   = 1'b1;
        addr1  = 8'h00;
    endtask

    // One access: drive, let the posedge capture it and the negedge commit
    // it, then advance the model the way the memory is meant to behave.
    task automatic doCycle(input logic c0, input logic w0, input logic [3:0] m0,
                           input logic [7:0] a0, input logic [31:0] d0,
                           input logic c1, input logic [7:0] a1);
        bit          accepted;
        logic [31:0] word;
        accepted = (edgeCnt >= 256);
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
        csb1 = c1; addr1 = a1;
        @(posedge clk0);
        @(negedge clk0);
        #1;
        if (accepted) begin
            if (!c0 && !w0) begin
                word = refMem[a0];
                for (int i = 0; i < 4; i++) begin
                    if (m0[i]) word[i*8 +: 8] = d0[i*8 +: 8];
                end
                refMem[a0] = word;
            end else if (!c0) begin
                refDout0 = refMem[a0];
            end
            if (!c1) refDout1 = refMem[a1];
        end
    endtask

    task automatic test_reset();
        int edges;
        idleInputs();
        rstb = 1'b0;
        refDout0 = 32'h0;
        refDout1 = 32'h0;
        #2;
        testsRun++;
        if (dout0 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_dout0: got %h want %h", dout0, 32'h0); end
        testsRun++;
        if (dout1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_dout1: got %h want %h", dout1, 32'h0); end
        testsRun++;
        if (init_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_init_done: got %b want 0", init_done); end
        repeat (2) @(posedge clk0);
        #1;
        rstb = 1'b1;
        // Hammer writes during the fill; none of them may land.
        edges = 0;
        while (init_done !== 1'b1 && edges < 400) begin
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
            addr0 = 8'($urandom); din0 = $urandom | 32'h1;
            csb1 = 1'b0; addr1 = 8'($urandom);
            @(posedge clk0);
            #1;
            edges++;
        end
        testsRun++;
        if (edges != 256) begin testsFailed++; $display("[TB] FAIL init_rise_edge: got %0d want 256", edges); end
        idleInputs();
        for (int a = 0; a < 256; a++) refMem[a] = 32'h0;
        for (int a = 0; a < 256; a++) begin
            doCycle(1'b0, 1'b1, 4'h0, 8'(a), 32'h0, 1'b0, 8'(255 - a));
            testsRun++;
            if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL zero_fill_p0[%0d]: got %h want %h", a, dout0, refDout0); end
            testsRun++;
            if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL zero_fill_p1[%0d]: got %h want %h", 255 - a, dout1, refDout1); end
        end
    endtask

    task automatic test_write_read();
        doCycle(1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00);
        testsRun++;
        if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL write_holds_dout0: got %h want %h", dout0, refDout0); end
        doCycle(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00);
        testsRun++;
        if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL read_back_model: got %h want %h", dout0, refDout0); end
        idleInputs();
        @(posedge clk0);
        #1;
        testsRun++;
        if (dout0 !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL read_back_next_posedge: got %h want %h", dout0, 32'hDEADBEEF); end
    endtask

    task automatic test_masked_write();
        doCycle(1'b0, 1'b0, 4'b0101, 8'h10, 32'h11223344, 1'b1, 8'h00);
        doCycle(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h10);
        testsRun++;
        if (dout0 !== 32'hDE22BE44) begin testsFailed++; $display("[TB] FAIL masked_const: got %h want %h", dout0, 32'hDE22BE44); end
        testsRun++;
        if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL masked_p0: got %h want %h", dout0, refDout0); end
        testsRun++;
        if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL masked_p1: got %h want %h", dout1, refDout1); end
        // A write with an empty mask changes nothing.
        doCycle(1'b0, 1'b0, 4'h0, 8'h10, 32'hFFFFFFFF, 1'b1, 8'h00);
        doCycle(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10);
        testsRun++;
        if (dout1 !== 32'hDE22BE44) begin testsFailed++; $display("[TB] FAIL empty_mask: got %h want %h", dout1, 32'hDE22BE44); end
    endtask

    task automatic test_write_first();
        doCycle(1'b0, 1'b0, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0, 8'h20);
        testsRun++;
        if (dout1 !== 32'hCAFEF00D) begin testsFailed++; $display("[TB] FAIL write_first_full: got %h want %h", dout1, 32'hCAFEF00D); end
        testsRun++;
        if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL write_first_dout0_hold: got %h want %h", dout0, refDout0); end
        doCycle(1'b0, 1'b0, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0, 8'h21);
        testsRun++;
        if (dout1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL other_addr_old: got %h want %h", dout1, 32'h0); end
        doCycle(1'b0, 1'b0, 4'b0011, 8'h20, 32'h12345678, 1'b0, 8'h20);
        testsRun++;
        if (dout1 !== 32'hCAFE5678) begin testsFailed++; $display("[TB] FAIL write_first_merged: got %h want %h", dout1, 32'hCAFE5678); end
        testsRun++;
        if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL write_first_model: got %h want %h", dout1, refDout1); end
    endtask

    task automatic test_deselect();
        doCycle(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h20);
        for (int i = 0; i < 3; i++) begin
            doCycle(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), $urandom, 1'b1, 8'($urandom));
            testsRun++;
            if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL deselect_dout0[%0d]: got %h want %h", i, dout0, refDout0); end
            testsRun++;
            if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL deselect_dout1[%0d]: got %h want %h", i, dout1, refDout1); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            doCycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                    8'($urandom_range(0, 15)), $urandom,
                    1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)));
            testsRun++;
            if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL random_dout0[%0d]: got %h want %h", i, dout0, refDout0); end
            testsRun++;
            if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL random_dout1[%0d]: got %h want %h", i, dout1, refDout1); end
        end
    endtask

    task automatic test_reset_mid_init();
        int edges;
        doCycle(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h20);
        testsRun++;
        if (dout0 !== 32'hDE22BE44) begin testsFailed++; $display("[TB] FAIL pre_reset_dout0: got %h want %h", dout0, 32'hDE22BE44); end
        idleInputs();
        rstb = 1'b0;
        refDout0 = 32'h0;
        refDout1 = 32'h0;
        #1;
        testsRun++;
        if (dout0 !== 32'h0 || dout1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL async_reset_douts: got %h/%h want 0/0", dout0, dout1); end
        @(posedge clk0);
        #1;
        rstb = 1'b1;
        repeat (100) @(posedge clk0);
        #1;
        testsRun++;
        if (init_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_init_done: got %b want 0", init_done); end
        rstb = 1'b0;
        #1;
        testsRun++;
        if (init_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset2_init_done: got %b want 0", init_done); end
        repeat (2) @(posedge clk0);
        #1;
        testsRun++;
        if (dout0 !== 32'h0 || dout1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset2_douts: got %h/%h want 0/0", dout0, dout1); end
        rstb = 1'b1;
        edges = 0;
        while (init_done !== 1'b1 && edges < 400) begin
            @(posedge clk0);
            #1;
            edges++;
        end
        testsRun++;
        if (edges != 256) begin testsFailed++; $display("[TB] FAIL restart_rise_edge: got %0d want 256", edges); end
        for (int a = 0; a < 256; a++) refMem[a] = 32'h0;
        for (int a = 0; a < 256; a++) begin
            doCycle(1'b0, 1'b1, 4'h0, 8'(a), 32'h0, 1'b0, 8'(a ^ 1));
            testsRun++;
            if (dout0 !== refDout0) begin testsFailed++; $display("[TB] FAIL refill_p0[%0d]: got %h want %h", a, dout0, refDout0); end
            testsRun++;
            if (dout1 !== refDout1) begin testsFailed++; $display("[TB] FAIL refill_p1[%0d]: got %h want %h", a ^ 1, dout1, refDout1); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_write_first();
        test_deselect();
        test_random();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
